// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//   MIPS32 MEM stage. Takes the EX/MEM bundle and performs byte/halfword/word
//   loads and stores against an internal byte-lane data RAM. Registers the
//   result into the MEM/WB bundle. Loads run through a small FSM that stalls
//   upstream for 1 + MEM_LATENCY cycles.
//
// Parameters
//   DEPTH_WORDS  data RAM depth in 32-bit words (power of two, >= 16)
//   MEM_LATENCY  extra wait cycles per load (0..15)
//
// Ports
//   clk       single clock, posedge
//   rst       synchronous active-high reset
//   in_valid  ex_mem carries a real instruction
//   ex_mem    {store_data[31:0], opcode[5:0], alu_result[31:0], dest_reg[4:0], is_r}
//   stall     load in flight, upstream must hold ex_mem
//   mem_wb    {opcode[5:0], wb_data[31:0], dest_reg[4:0], is_load}
//   wb_valid  mem_wb holds a real instruction
//   misalign  registered with mem_wb, access was misaligned
//
// Build option
//   MEM_MISALIGN_TRAP_EN  defined: misaligned halfword/word accesses are flagged,
//                         stores suppressed, loads return 0 in one cycle.
//                         undefined: low address bits forced to zero, misalign = 0.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int DEPTH_WORDS = 1024,
   parameter int MEM_LATENCY = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [75:0] ex_mem,
   output logic        stall,
   output logic [43:0] mem_wb,
   output logic        wb_valid,
   output logic        misalign
);

   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   // EX/MEM field split
   logic [31:0]   store_data;
   logic [5:0]    opcode;
   logic [31:0]   alu_result;
   logic [4:0]    dest_reg;
   logic          is_r;

   assign store_data = ex_mem[75:44];
   assign opcode     = ex_mem[43:38];
   assign alu_result = ex_mem[37:6];
   assign dest_reg   = ex_mem[5:1];
   assign is_r       = ex_mem[0];

   // is_r and the wrapped upper address bits do not affect this stage
   logic unused_bits;
   assign unused_bits = ^{is_r, alu_result[31:AW+2]};

   state_t        state, state_next;
   logic [3:0]    cnt, cnt_next;

   logic          is_load_op, is_store_op, is_half, is_word;
   logic          mis;
   logic [1:0]    eff_off;
   logic [AW-1:0] word_idx;
   logic          load_fire, store_fire;
   logic [3:0]    be;
   logic [31:0]   wdata;

   logic [31:0]   ram [DEPTH_WORDS];
   logic [31:0]   rd_word;
   logic [5:0]    ld_op;
   logic [1:0]    ld_off;
   logic [4:0]    ld_dest;
   logic [31:0]   ld_data;
   logic [31:0]   pass_data;

   // Opcode decode
   always_comb begin
      is_load_op  = 1'b0;
      is_store_op = 1'b0;
      is_half     = 1'b0;
      is_word     = 1'b0;
      case (opcode)
         OP_LB, OP_LBU: is_load_op = 1'b1;
         OP_LH, OP_LHU: begin is_load_op = 1'b1; is_half = 1'b1; end
         OP_LW:         begin is_load_op = 1'b1; is_word = 1'b1; end
         OP_SB:         is_store_op = 1'b1;
         OP_SH:         begin is_store_op = 1'b1; is_half = 1'b1; end
         OP_SW:         begin is_store_op = 1'b1; is_word = 1'b1; end
         default:       ;
      endcase
   end

`ifdef MEM_MISALIGN_TRAP_EN
   assign mis = (is_half & alu_result[0]) | (is_word & (|alu_result[1:0]));
`else
   assign mis = 1'b0;
`endif

   // Lane offset with the low bits that a halfword/word cannot use cleared;
   // in trap mode misaligned accesses never reach the RAM, so this is safe.
   assign eff_off  = is_word ? 2'b00 : (is_half ? {alu_result[1], 1'b0} : alu_result[1:0]);
   assign word_idx = alu_result[AW+1:2];

   // New work is accepted only in IDLE; in WAIT/RESP ex_mem still holds the load.
   assign load_fire  = in_valid & (state == ST_IDLE) & is_load_op  & ~mis;
   assign store_fire = in_valid & (state == ST_IDLE) & is_store_op & ~mis;

   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0;
      case (opcode)
         OP_SB: begin be = 4'b0001 << eff_off; wdata = {4{store_data[7:0]}};  end
         OP_SH: begin be = 4'b0011 << eff_off; wdata = {2{store_data[15:0]}}; end
         OP_SW: begin be = 4'b1111;            wdata = store_data;            end
         default: ;
      endcase
   end

   // NOTE: the RAM and its read/capture registers have no reset; every value
   // they hold is written before it is used, and resetting an array would
   // prevent mapping it onto a memory macro.
   always_ff @(posedge clk) begin
      if (store_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (load_fire) begin
         rd_word <= ram[word_idx];
         ld_op   <= opcode;
         ld_off  <= eff_off;
         ld_dest <= dest_reg;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // NOTE: every output of this block gets a default first so no latch is
   // inferred on paths that do not assign it.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_fire) begin
               stall = 1'b1;
               if (MEM_LATENCY > 0) begin
                  state_next = ST_WAIT;
                  cnt_next   = 4'(MEM_LATENCY);
               end else begin
                  state_next = ST_RESP;
               end
            end
         end
         ST_WAIT: begin
            stall    = 1'b1;
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) state_next = ST_RESP;
         end
         ST_RESP: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Load data formatting from the captured word
   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b = rd_word[8*ld_off +: 8];
      lane_h = ld_off[1] ? rd_word[31:16] : rd_word[15:0];
      case (ld_op)
         OP_LB:   ld_data = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  ld_data = {24'h0, lane_b};
         OP_LH:   ld_data = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  ld_data = {16'h0, lane_h};
         default: ld_data = rd_word;
      endcase
   end

   // Trapped misaligned loads return zero; everything else in the IDLE
   // pass-through path returns the ALU result.
   assign pass_data = (mis & is_load_op) ? 32'h0 : alu_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wb   <= 44'h0;
         wb_valid <= 1'b0;
         misalign <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (load_fire) begin
                  wb_valid <= 1'b0;
               end else begin
                  mem_wb   <= {opcode, pass_data, dest_reg, is_load_op};
                  wb_valid <= in_valid;
                  misalign <= mis & in_valid;
               end
            end
            ST_RESP: begin
               mem_wb   <= {ld_op, ld_data, ld_dest, 1'b1};
               wb_valid <= 1'b1;
               misalign <= 1'b0;
            end
            default: wb_valid <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed, table-driven bench for mem_access_unit built with MEM_LATENCY=3.
//   Each table record gives one EX/MEM instruction and the MEM/WB result,
//   stall length and misalign flag it must produce. Hand-written sequences
//   cover reset/idle and reset during a load wait.
//   Expected values for misaligned accesses follow MEM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

   localparam int LAT = 3;
   localparam int LD_STALL = 1 + LAT;

   localparam logic [5:0] OP_R   = 6'd0;
   localparam logic [5:0] OP_LB  = 6'd32;
   localparam logic [5:0] OP_LH  = 6'd33;
   localparam logic [5:0] OP_LW  = 6'd35;
   localparam logic [5:0] OP_LBU = 6'd36;
   localparam logic [5:0] OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB  = 6'd40;
   localparam logic [5:0] OP_SH  = 6'd41;
   localparam logic [5:0] OP_SW  = 6'd43;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [75:0] ex_mem;
   logic        stall;
   logic [43:0] mem_wb;
   logic        wb_valid;
   logic        misalign;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        valid;
      logic [5:0]  op;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  dest;
      logic [31:0] exp_data;
      logic        exp_ld;
      int          exp_stall;
      logic        exp_mis;
   } vec_t;

   vec_t tbl[$];

   mem_access_unit #(.DEPTH_WORDS(1024), .MEM_LATENCY(LAT)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .ex_mem   (ex_mem),
      .stall    (stall),
      .mem_wb   (mem_wb),
      .wb_valid (wb_valid),
      .misalign (misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [5:0] op, input logic [31:0] alu,
                               input logic [31:0] sd, input logic [4:0] dest,
                               input logic [31:0] data, input logic ld, input int stl,
                               input logic mis);
      vec_t r;
      r.valid = v; r.op = op; r.alu = alu; r.sd = sd; r.dest = dest;
      r.exp_data = data; r.exp_ld = ld; r.exp_stall = stl; r.exp_mis = mis;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one instruction at posedge+1, follow stall, then check the
   // MEM/WB bundle one edge after stall drops.
   task automatic apply(input vec_t v, input string tag);
      int   cycles;
      logic bubble_bad;
      in_valid = v.valid;
      ex_mem   = {v.sd, v.op, v.alu, v.dest, (v.op == OP_R)};
      #1;
      cycles     = 0;
      bubble_bad = 1'b0;
      while (stall && cycles < 40) begin
         cycles++;
         @(posedge clk);
         #2;
         if (wb_valid !== 1'b0) bubble_bad = 1'b1;
      end
      check({tag, " stall_cycles"}, 64'(cycles), 64'(v.exp_stall));
      if (v.exp_stall > 0) check({tag, " bubble"}, 64'(bubble_bad), 64'(0));
      @(posedge clk);
      #1;
      check({tag, " wb_valid"}, 64'(wb_valid), 64'(v.valid));
      if (v.valid) begin
         check({tag, " mem_wb"}, 64'(mem_wb), 64'({v.op, v.exp_data, v.dest, v.exp_ld}));
         check({tag, " misalign"}, 64'(misalign), 64'(v.exp_mis));
      end
   endtask

   initial begin
      logic flag;

      rst      = 1'b1;
      in_valid = 1'b0;
      ex_mem   = '0;

      // Reset then idle
      step();
      step();
      check("rst mem_wb", 64'(mem_wb), 64'(0));
      check("rst wb_valid", 64'(wb_valid), 64'(0));
      rst = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (mem_wb !== 44'h0 || wb_valid !== 1'b0 || stall !== 1'b0) flag = 1'b1;
      end
      check("idle outputs", 64'(flag), 64'(0));

      //         v  op      alu            sd             dst   data           ld  stall     mis
      tbl.push_back(mk(1, OP_SW,  32'h10,   32'hDEADBEEF, 5'd0, 32'h00000010, 0, 0,        0));
      tbl.push_back(mk(1, OP_LB,  32'h13,   32'h0,        5'd5, 32'hFFFFFFDE, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LBU, 32'h13,   32'h0,        5'd6, 32'h000000DE, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LH,  32'h10,   32'h0,        5'd7, 32'hFFFFBEEF, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LHU, 32'h10,   32'h0,        5'd8, 32'h0000BEEF, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LH,  32'h12,   32'h0,        5'd9, 32'hFFFFDEAD, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LB,  32'h11,   32'h0,        5'd1, 32'hFFFFFFBE, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_SB,  32'h11,   32'hAAAAAA55, 5'd0, 32'h00000011, 0, 0,        0));
      tbl.push_back(mk(1, OP_LW,  32'h10,   32'h0,        5'd3, 32'hDEAD55EF, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_R,   32'h12345678, 32'h0,    5'd7, 32'h12345678, 0, 0,        0));
      tbl.push_back(mk(1, OP_SW,  32'h14,   32'h00000000, 5'd0, 32'h00000014, 0, 0,        0));
      tbl.push_back(mk(1, OP_SH,  32'h16,   32'h1234CAFE, 5'd0, 32'h00000016, 0, 0,        0));
      tbl.push_back(mk(1, OP_LW,  32'h14,   32'h0,        5'd4, 32'hCAFE0000, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LHU, 32'h16,   32'h0,        5'd2, 32'h0000CAFE, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_LB,  32'h17,   32'h0,        5'd2, 32'hFFFFFFCA, 1, LD_STALL, 0));
      tbl.push_back(mk(0, OP_R,   32'h0BADF00D, 32'h0,    5'd3, 32'h0,        0, 0,        0));
      tbl.push_back(mk(1, OP_SW,  32'h1020, 32'hA5A5A5A5, 5'd0, 32'h00001020, 0, 0,        0));
      tbl.push_back(mk(1, OP_LW,  32'h20,   32'h0,        5'd11, 32'hA5A5A5A5, 1, LD_STALL, 0));
`ifdef MEM_MISALIGN_TRAP_EN
      tbl.push_back(mk(1, OP_LW,  32'h12,   32'h0,        5'd9, 32'h00000000, 1, 0,        1));
      tbl.push_back(mk(1, OP_SH,  32'h11,   32'h00001234, 5'd0, 32'h00000011, 0, 0,        1));
      tbl.push_back(mk(1, OP_LW,  32'h10,   32'h0,        5'd9, 32'hDEAD55EF, 1, LD_STALL, 0));
`else
      tbl.push_back(mk(1, OP_LW,  32'h12,   32'h0,        5'd9, 32'hDEAD55EF, 1, LD_STALL, 0));
      tbl.push_back(mk(1, OP_SH,  32'h11,   32'h00001234, 5'd0, 32'h00000011, 0, 0,        0));
      tbl.push_back(mk(1, OP_LW,  32'h10,   32'h0,        5'd9, 32'hDEAD1234, 1, LD_STALL, 0));
`endif
      tbl.push_back(mk(1, OP_R,   32'h00C0FFEE, 32'h0,    5'd31, 32'h00C0FFEE, 0, 0,       0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

      // Reset while the load sits in WAIT: nothing may be written back
      in_valid = 1'b1;
      ex_mem   = {32'h0, OP_LW, 32'h14, 5'd12, 1'b0};
      #1;
      check("midrst stall_issue", 64'(stall), 64'(1));
      step();
      step();
      check("midrst stall_wait", 64'(stall), 64'(1));
      rst      = 1'b1;
      in_valid = 1'b0;
      step();
      check("midrst stall_after", 64'(stall), 64'(0));
      check("midrst wb_valid", 64'(wb_valid), 64'(0));
      check("midrst mem_wb", 64'(mem_wb), 64'(0));
      rst  = 1'b0;
      flag = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (wb_valid !== 1'b0 || stall !== 1'b0) flag = 1'b1;
      end
      check("midrst no_writeback", 64'(flag), 64'(0));

      // RAM contents survive reset
      apply(mk(1, OP_LW, 32'h20, 32'h0, 5'd13, 32'hA5A5A5A5, 1, LD_STALL, 0), "post_rst");

      in_valid = 1'b0;
      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
